// File: rtl/alu_seq_handshake_if.sv
// Handshake bundle between operand fetch, the sequential ALU and writeback.
// The slave side is the ALU; the master side drives operands and consumes results.
interface alu_seq_handshake_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] operand0;
    logic [WIDTH-1:0] operand1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             carryflag;
    logic             signflag;
    logic             overflowflag;
    logic             zflag;
    logic             busy;

    modport slave (
        input  in_valid, alu_control, operand0, operand1, out_ready,
        output in_ready, out_valid, ALUResult, carryflag, signflag,
               overflowflag, zflag, busy
    );

    modport master (
        output in_valid, alu_control, operand0, operand1, out_ready,
        input  in_ready, out_valid, ALUResult, carryflag, signflag,
               overflowflag, zflag, busy
    );
endinterface

// File: rtl/alu_seq_handshake.sv
// Registered ALU with valid/ready handshake on both sides and an iterative
// shift-add multiplier that retires one multiplier bit per clock.
module alu_seq_handshake #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_seq_handshake_if.slave    bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               sign_q, sign_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    logic               in_ready_s;
    logic               accept_s;
    logic               is_sub_s;
    logic [WIDTH-1:0]   b_eff_s;
    logic [WIDTH:0]     sum_s;
    logic               add_ovf_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_c_s;
    logic               alu_v_s;
    logic [2*WIDTH-1:0] acc_step_s;

    // Input acceptance: free in IDLE, or in HOLD when the current result leaves this edge.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            ST_IDLE: in_ready_s = 1'b1;
            ST_HOLD: in_ready_s = bus.out_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    assign accept_s = bus.in_valid & in_ready_s;

    // Single-cycle datapath; SLT reuses the subtractor and corrects the sign with overflow.
    always_comb begin
        is_sub_s  = (bus.alu_control == OP_SUB) || (bus.alu_control == OP_SLT);
        b_eff_s   = is_sub_s ? ~bus.operand1 : bus.operand1;
        sum_s     = {1'b0, bus.operand0} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, is_sub_s};
        add_ovf_s = (bus.operand0[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                    (sum_s[WIDTH-1] != bus.operand0[WIDTH-1]);
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (bus.alu_control)
            OP_ADD, OP_SUB: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = add_ovf_s;
            end
            OP_AND:  alu_res_s = bus.operand0 & bus.operand1;
            OP_OR:   alu_res_s = bus.operand0 | bus.operand1;
            OP_XOR:  alu_res_s = bus.operand0 ^ bus.operand1;
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ add_ovf_s};
            OP_SLL:  alu_res_s = bus.operand0 << bus.operand1[SHW-1:0];
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    assign acc_step_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

    // Next-state and register-update logic for the IDLE/MUL_RUN/HOLD controller.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        sign_d   = sign_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept_s && (bus.alu_control == OP_MUL)) begin
                    state_d  = ST_MUL_RUN;
                    acc_d    = {(2*WIDTH){1'b0}};
                    mcand_d  = {{WIDTH{1'b0}}, bus.operand0};
                    mplier_d = bus.operand1;
                    cnt_d    = {SHW{1'b0}};
                end else if (accept_s) begin
                    state_d  = ST_HOLD;
                    result_d = alu_res_s;
                    carry_d  = alu_c_s;
                    ovf_d    = alu_v_s;
                    sign_d   = alu_res_s[WIDTH-1];
                    zero_d   = (alu_res_s == {WIDTH{1'b0}});
                end else if ((state_q == ST_HOLD) && bus.out_ready) begin
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = state_q;
                end
            end
            ST_MUL_RUN: begin
                acc_d    = acc_step_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d  = ST_HOLD;
                    result_d = acc_step_s[WIDTH-1:0];
                    carry_d  = 1'b0;
                    ovf_d    = |acc_step_s[2*WIDTH-1:WIDTH];
                    sign_d   = acc_step_s[WIDTH-1];
                    zero_d   = (acc_step_s[WIDTH-1:0] == {WIDTH{1'b0}});
                end else begin
                    state_d  = ST_MUL_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, result and multiplier registers; reset discards any in-flight multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= {WIDTH{1'b0}};
            carry_q  <= 1'b0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {SHW{1'b0}};
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            sign_q   <= sign_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = (state_q == ST_HOLD);
    assign bus.busy         = (state_q == ST_MUL_RUN);
    assign bus.ALUResult    = result_q;
    assign bus.carryflag    = carry_q;
    assign bus.signflag     = sign_q;
    assign bus.overflowflag = ovf_q;
    assign bus.zflag        = zero_q;
endmodule

// File: tb/tb_alu_seq_handshake.sv
// Scoreboard bench for alu_seq_handshake: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every output transfer.
module tb_alu_seq_handshake;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_handshake_if #(.WIDTH(W)) bus ();
    alu_seq_handshake #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic        c, s, v, z;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every output transfer must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: actual=%h required=none", bus.ALUResult);
            end else begin
                e = sb_q.pop_front();
                check(e.name,
                      64'({bus.ALUResult, bus.carryflag, bus.signflag, bus.overflowflag, bus.zflag}),
                      64'({e.res, e.c, e.s, e.v, e.z}));
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ec, input logic es,
                        input logic ev, input logic ez, input string name);
        exp_t e;
        bit   ok;
        e.res = er; e.c = ec; e.s = es; e.v = ev; e.z = ez; e.name = name;
        bus.alu_control = op;
        bus.operand0    = a;
        bus.operand1    = b;
        bus.in_valid    = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: actual=timeout required=in_ready", name);
            bus.in_valid = 1'b0;
            return;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (op == 3'd7)
            check({name, "_start"}, 64'({bus.busy, bus.in_ready, bus.out_valid}), 64'(3'b100));
        else
            check({name, "_latency"}, 64'(bus.out_valid), 64'(1'b1));
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        int bad;
        bus.in_valid    = 1'b0;
        bus.alu_control = 3'd0;
        bus.operand0    = 32'd0;
        bus.operand1    = 32'd0;
        bus.out_ready   = 1'b1;

        #12;
        check("rst_ctrl", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'(3'b100));
        check("rst_result", 64'(bus.ALUResult), 64'(0));
        check("rst_flags", 64'({bus.carryflag, bus.signflag, bus.overflowflag, bus.zflag}), 64'(4'b0000));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(3'd0, 32'd8, 32'd6, 32'd14, 1'b0, 1'b0, 1'b0, 1'b0, "add_8_6");
        send(3'd1, 32'd6, 32'd8, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0, "sub_6_8");
        send(3'd1, 32'd8, 32'd8, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, "sub_8_8");
        send(3'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0, "add_ovf");
        send(3'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, "add_carry");

        // Multiply straight after a held result: out_valid must drop while iterating.
        send(3'd7, 32'd8, 32'd6, 32'd48, 1'b0, 1'b0, 1'b0, 1'b0, "mul_8x6");
        bad = 0;
        for (int i = 1; i < 32; i++) begin
            @(posedge clk);
            #1;
            if (!(bus.busy && !bus.in_ready && !bus.out_valid)) bad++;
        end
        check("mul_busy_span", 64'(bad), 64'(0));
        @(posedge clk);
        #1;
        check("mul_done_edge", 64'({bus.out_valid, bus.busy}), 64'(2'b10));

        send(3'd7, 32'h00010000, 32'h00010000, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, "mul_hi_ovf");
        send(3'd5, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, "slt_neg");
        send(3'd5, 32'h7FFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, "slt_ovf0");
        send(3'd5, 32'h80000000, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, "slt_ovf1");
        send(3'd2, 32'hF0F0F0F0, 32'hFFFF0000, 32'hF0F00000, 1'b0, 1'b1, 1'b0, 1'b0, "and");
        send(3'd3, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0, "or");
        drain();

        // Backpressure: result must hold while writeback stalls, then back-to-back accept.
        bus.out_ready = 1'b0;
        send(3'd4, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1'b0, 1'b0, 1'b0, 1'b0, "xor_hold");
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if ({bus.ALUResult, bus.out_valid, bus.in_ready} !== {32'h0F0FF0F0, 1'b1, 1'b0}) bad++;
        end
        check("hold_stable", 64'(bad), 64'(0));
        bus.out_ready = 1'b1;
        send(3'd6, 32'd1, 32'd35, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0, "sll_b2b");
        drain();

        // Reset in the middle of a multiply.
        send(3'd7, 32'd8, 32'd6, 32'd48, 1'b0, 1'b0, 1'b0, 1'b0, "mul_rst");
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'(3'b001));
        check("midrst_result", 64'(bus.ALUResult), 64'(0));
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(3'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, "add_after_rst");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq_handshake.md
Name: alu_seq_handshake

Overview:
- Parametrised, registered successor to ArithmeticLogicUnit. Keeps the same 3-bit opcode space and the same flag set.
- Adds a valid/ready handshake on input and output, registered results, and an iterative multi-cycle shift-add multiply.
- Sits between decode/operand fetch and writeback in the RISC datapath; writeback may stall it via out_ready.

Parameters:
- WIDTH, 32, operand/result width; power of two, ≥8.
- SHW, $clog2(WIDTH), shift-amount bits taken from operand1 (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept a new operation this cycle
- alu_control  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 MUL (low WIDTH bits)
- operand0  input  WIDTH  first operand
- operand1  input  WIDTH  second operand / shift amount
- out_valid  output  1  ALUResult and flags valid
- out_ready  input  1  consumer accepts the result
- ALUResult  output  WIDTH  registered result
- carryflag  output  1  registered carry
- signflag  output  1  registered sign
- overflowflag  output  1  registered overflow
- zflag  output  1  registered zero
- busy  output  1  MUL iteration in progress

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; busy=0; ALUResult=0; all flags=0. Takes effect immediately, mid-operation included; the in-flight MUL is discarded.
- Transfer rules: input transfer = in_valid & in_ready at a rising edge. Output transfer = out_valid & out_ready.
- States: IDLE, MUL_RUN, HOLD.
  - in_ready = (state==IDLE) | (state==HOLD & out_ready).
  - Inputs are ignored whenever in_ready=0.
- Ops 0–6 (single-cycle):
  - Accepted at edge k → result and flags registered at edge k; out_valid=1 after edge k; state HOLD.
- MUL (op 7):
  - Accepted at edge k → latch operands, clear 2*WIDTH accumulator, state MUL_RUN, busy=1.
  - Edges k+1..k+WIDTH each process one multiplier bit, LSB first.
  - After edge k+WIDTH: ALUResult = product[WIDTH-1:0], out_valid=1, busy=0, state HOLD.
- HOLD:
  - ALUResult and flags remain stable while out_valid=1 & out_ready=0.
  - On out_ready=1 with no new input: out_valid clears, state IDLE.
  - On out_ready=1 with in_valid=1 (simultaneous events): the new op is accepted the same edge (back-to-back), so out_valid stays 1 for single-cycle ops and drops to 0 for MUL.
- Arithmetic (all modulo 2^WIDTH):
  - ADD: carry = carry-out of operand0+operand1.
  - SUB: computed as operand0 + ~operand1 + 1; carry = carry-out, so 1 means no borrow.
  - Overflow on ADD/SUB = signed overflow.
  - SLT: result = 1 if $signed(operand0) < $signed(operand1), else 0; must be correct under overflow of the internal subtraction.
  - SLL: shift by operand1[SHW-1:0]; upper operand1 bits are ignored.
  - MUL: unsigned; overflowflag = 1 if product[2*WIDTH-1:WIDTH] ≠ 0.
- Flags:
  - carryflag = 0 and overflowflag = 0 for AND/OR/XOR/SLT/SLL/MUL, except the MUL overflow rule above.
  - signflag = ALUResult[WIDTH-1].
  - zflag = (ALUResult==0).
- Invalid states: any illegal state encoding returns to IDLE.

Test Plan (WIDTH=32):
- ADD 8+6, out_ready=1 → one cycle after accept: out_valid=1, ALUResult=14, carry=0, sign=0, ovf=0, z=0.
- SUB 6−8 → ALUResult=0xFFFFFFFE, carry=0, sign=1, z=0. SUB 8−8 → ALUResult=0, carry=1, z=1.
- ADD 0x7FFFFFFF+1 → 0x80000000, ovf=1, sign=1, carry=0. ADD 0xFFFFFFFF+1 → 0, carry=1, z=1, ovf=0.
- MUL 8×6 → busy=1 for 32 cycles, in_ready=0 throughout; out_valid after edge k+32 with ALUResult=48, ovf=0. MUL 0x10000×0x10000 → ALUResult=0, ovf=1, z=1.
- Backpressure: XOR 0xF0F0F0F0^0xFFFF0000 with out_ready=0 for 5 cycles → ALUResult=0x0F0FF0F0 held stable, in_ready=0; then out_ready=1 with in_valid=1, SLL 1<<35 → accepted the same edge; next result 0x00000008.
- Reset mid-MUL: drop rst_n for 1 cycle at iteration 10 → out_valid=0, busy=0, ALUResult=0 immediately; the next ADD 1+1 → 2 with normal latency.
